// File: rtl/varredura_display_if.sv
// Bus between the counter datapath / conversor side and the scan controller.
interface varredura_display_if #(
    parameter int unsigned N_DIGITS = 4
);
    logic                      enable;
    logic                      load;
    logic [4*N_DIGITS-1:0]     digitos;
    logic                      lz_blank;
    logic [3:0]                nibble;
    logic [N_DIGITS-1:0]       anodo;
    logic                      apagado;
    logic                      fim_quadro;

    modport master (
        output enable, load, digitos, lz_blank,
        input  nibble, anodo, apagado, fim_quadro
    );

    modport slave (
        input  enable, load, digitos, lz_blank,
        output nibble, anodo, apagado, fim_quadro
    );
endinterface

// File: rtl/varredura_display.sv
// Time-multiplexed 7-segment scan controller: guard/show slots per digit,
// frame-atomic digit snapshot and optional leading-zero suppression.
module varredura_display #(
    parameter int unsigned N_DIGITS = 4,
    parameter int unsigned PRESCALE = 4,
    parameter int unsigned GUARD    = 1
) (
    input  logic               clock,
    input  logic               reset,
    varredura_display_if.slave bus
);
    localparam int unsigned T_MAX   = (PRESCALE > GUARD) ? PRESCALE : GUARD;
    localparam int unsigned TIMER_W = $clog2(T_MAX) + 1;
    localparam int unsigned INDEX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    localparam logic [TIMER_W-1:0]  GUARD_LAST = TIMER_W'(GUARD - 1);
    localparam logic [TIMER_W-1:0]  SHOW_LAST  = TIMER_W'(PRESCALE - 1);
    localparam logic [INDEX_W-1:0]  LAST_IDX   = INDEX_W'(N_DIGITS - 1);
    localparam logic [N_DIGITS-1:0] ONE_HOT0   = N_DIGITS'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GUARD = 2'd1,
        ST_SHOW  = 2'd2
    } state_t;

    state_t                      state_q, state_d;
    logic [INDEX_W-1:0]          index_q, index_d;
    logic [TIMER_W-1:0]          timer_q, timer_d;
    logic [N_DIGITS-1:0][3:0]    shadow_q, shadow_d;
    logic [N_DIGITS-1:0][3:0]    pending_q, pending_d;
    logic                        pend_valid_q, pend_valid_d;
    logic [3:0]                  nibble_q, nibble_d;
    logic [N_DIGITS-1:0]         anodo_q, anodo_d;
    logic                        apagado_q, apagado_d;
    logic                        fim_quadro_q, fim_quadro_d;

    logic                        boundary_c;
    logic                        zero_above_c;
    logic [N_DIGITS-1:0]         supp_c;

    // Next-state, snapshot management and next-output computation.
    always_comb begin
        state_d      = state_q;
        index_d      = index_q;
        timer_d      = timer_q;
        shadow_d     = shadow_q;
        pending_d    = pending_q;
        pend_valid_d = pend_valid_q;
        nibble_d     = nibble_q;
        anodo_d      = '0;
        apagado_d    = 1'b1;
        fim_quadro_d = 1'b0;
        zero_above_c = 1'b1;
        supp_c       = '0;

        boundary_c = (state_q == ST_SHOW) && (index_q == LAST_IDX) &&
                     (timer_q == SHOW_LAST);

        // Scan sequencing; dropping enable abandons the slot immediately.
        if (!bus.enable) begin
            state_d = ST_IDLE;
            index_d = '0;
            timer_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_GUARD;
                    index_d = '0;
                    timer_d = '0;
                end
                ST_GUARD: begin
                    if (timer_q == GUARD_LAST) begin
                        state_d = ST_SHOW;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + TIMER_W'(1);
                    end
                end
                ST_SHOW: begin
                    if (timer_q == SHOW_LAST) begin
                        state_d = ST_GUARD;
                        timer_d = '0;
                        index_d = (index_q == LAST_IDX) ? '0 : index_q + INDEX_W'(1);
                    end else begin
                        timer_d = timer_q + TIMER_W'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    index_d = '0;
                    timer_d = '0;
                end
            endcase
        end

        // Snapshot only moves while idle or at the frame boundary.
        if (state_q == ST_IDLE) begin
            if (bus.load) begin
                shadow_d = bus.digitos;
            end
        end else if (boundary_c) begin
            if (bus.load) begin
                shadow_d = bus.digitos;
            end else if (pend_valid_q) begin
                shadow_d = pending_q;
            end
            pend_valid_d = 1'b0;
        end else if (bus.load) begin
            pending_d    = bus.digitos;
            pend_valid_d = 1'b1;
        end

        // Digit k is blank when it and every higher digit are zero (never digit 0).
        for (int k = N_DIGITS - 1; k >= 0; k--) begin
            zero_above_c = zero_above_c && (shadow_d[k] == 4'd0);
            supp_c[k]    = bus.lz_blank && (k != 0) && zero_above_c;
        end

        // Outputs describe the cycle being entered, so they use next values.
        nibble_d = shadow_d[index_d];
        if (state_d == ST_SHOW) begin
            if (!supp_c[index_d]) begin
                anodo_d   = ONE_HOT0 << index_d;
                apagado_d = 1'b0;
            end
            fim_quadro_d = (index_d == LAST_IDX) && (timer_d == SHOW_LAST);
        end
    end

    // State and output registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            index_q      <= '0;
            timer_q      <= '0;
            shadow_q     <= '0;
            pending_q    <= '0;
            pend_valid_q <= 1'b0;
            nibble_q     <= 4'd0;
            anodo_q      <= '0;
            apagado_q    <= 1'b1;
            fim_quadro_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            index_q      <= index_d;
            timer_q      <= timer_d;
            shadow_q     <= shadow_d;
            pending_q    <= pending_d;
            pend_valid_q <= pend_valid_d;
            nibble_q     <= nibble_d;
            anodo_q      <= anodo_d;
            apagado_q    <= apagado_d;
            fim_quadro_q <= fim_quadro_d;
        end
    end

    assign bus.nibble     = nibble_q;
    assign bus.anodo      = anodo_q;
    assign bus.apagado    = apagado_q;
    assign bus.fim_quadro = fim_quadro_q;
endmodule

// File: tb/tb_varredura_display.sv
// Directed bench for varredura_display with default parameters (4 digits,
// 4 show cycles, 1 guard cycle).
module tb_varredura_display;
    localparam int unsigned N_DIGITS = 4;
    localparam int unsigned PRESCALE = 4;
    localparam int unsigned GUARD    = 1;

    logic clock;
    logic reset;
    int   errors;
    int   checks;

    varredura_display_if #(.N_DIGITS(N_DIGITS)) bus ();

    varredura_display #(
        .N_DIGITS (N_DIGITS),
        .PRESCALE (PRESCALE),
        .GUARD    (GUARD)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [3:0] nib, input logic [3:0] an,
                           input logic ap, input logic fim);
        chk({tag, ".nibble"},     32'(bus.nibble),     32'(nib));
        chk({tag, ".anodo"},      32'(bus.anodo),      32'(an));
        chk({tag, ".apagado"},    32'(bus.apagado),    32'(ap));
        chk({tag, ".fim_quadro"}, 32'(bus.fim_quadro), 32'(fim));
    endtask

    // One slot: guard cycle then n_show show cycles; optional load before step load_at.
    task automatic slot(input string tag, input int idx, input logic [3:0] nib, input logic lit,
                        input int n_show, input int load_at, input logic [15:0] load_val);
        logic [3:0] an_exp;
        an_exp = lit ? 4'(4'b0001 << idx) : 4'b0000;
        for (int c = 0; c <= n_show; c++) begin
            if (c == load_at) begin
                bus.load    = 1'b1;
                bus.digitos = load_val;
            end
            step();
            bus.load = 1'b0;
            if (c == 0)
                chk_out({tag, ".guard"}, nib, 4'b0000, 1'b1, 1'b0);
            else
                chk_out({tag, ".show"}, nib, an_exp, ~lit,
                        (idx == N_DIGITS - 1) && (c == PRESCALE));
        end
    endtask

    initial begin
        errors       = 0;
        checks       = 0;
        reset        = 1'b1;
        bus.enable   = 1'b0;
        bus.load     = 1'b0;
        bus.digitos  = 16'h0000;
        bus.lz_blank = 1'b0;
        #1;
        chk_out("reset", 4'h0, 4'b0000, 1'b1, 1'b0);
        #1;
        reset = 1'b0;

        // Idle load, then start scanning.
        bus.load    = 1'b1;
        bus.digitos = 16'h4321;
        step();
        bus.load   = 1'b0;
        chk_out("idle", 4'h1, 4'b0000, 1'b1, 1'b0);
        bus.enable = 1'b1;

        // Frame 1: 1,2,3,4.
        slot("f1s0", 0, 4'h1, 1'b1, 4, -1, 16'h0);
        slot("f1s1", 1, 4'h2, 1'b1, 4, -1, 16'h0);
        slot("f1s2", 2, 4'h3, 1'b1, 4, -1, 16'h0);
        slot("f1s3", 3, 4'h4, 1'b1, 4, -1, 16'h0);

        // Frame 2: load during index 1 does not disturb this frame.
        slot("f2s0", 0, 4'h1, 1'b1, 4, -1, 16'h0);
        slot("f2s1", 1, 4'h2, 1'b1, 4, 2, 16'h9876);
        slot("f2s2", 2, 4'h3, 1'b1, 4, -1, 16'h0);
        slot("f2s3", 3, 4'h4, 1'b1, 4, -1, 16'h0);

        // Frame 3: pending applied; two loads queued, last one wins.
        slot("f3s0", 0, 4'h6, 1'b1, 4, -1, 16'h0);
        slot("f3s1", 1, 4'h7, 1'b1, 4, 2, 16'h1111);
        slot("f3s2", 2, 4'h8, 1'b1, 4, 2, 16'h2222);
        slot("f3s3", 3, 4'h9, 1'b1, 4, -1, 16'h0);

        // Frame 4: shows 2222; queue 3333 that the boundary load must override.
        slot("f4s0", 0, 4'h2, 1'b1, 4, -1, 16'h0);
        slot("f4s1", 1, 4'h2, 1'b1, 4, 2, 16'h3333);
        slot("f4s2", 2, 4'h2, 1'b1, 4, -1, 16'h0);
        slot("f4s3", 3, 4'h2, 1'b1, 4, -1, 16'h0);

        // Frame 5: load on boundary cycle goes straight to shadow.
        slot("f5s0", 0, 4'h5, 1'b1, 4, 0, 16'h0005);
        slot("f5s1", 1, 4'h0, 1'b1, 4, -1, 16'h0);
        slot("f5s2", 2, 4'h0, 1'b1, 4, -1, 16'h0);
        slot("f5s3", 3, 4'h0, 1'b1, 4, -1, 16'h0);

        // Frame 6: nothing pending anymore, still 0005.
        slot("f6s0", 0, 4'h5, 1'b1, 4, -1, 16'h0);
        slot("f6s1", 1, 4'h0, 1'b1, 4, -1, 16'h0);
        slot("f6s2", 2, 4'h0, 1'b1, 4, -1, 16'h0);
        slot("f6s3", 3, 4'h0, 1'b1, 4, -1, 16'h0);

        // Frame 7: leading-zero suppression on 0070.
        bus.lz_blank = 1'b1;
        slot("f7s0", 0, 4'h0, 1'b1, 4, 0, 16'h0070);
        slot("f7s1", 1, 4'h7, 1'b1, 4, -1, 16'h0);
        slot("f7s2", 2, 4'h0, 1'b0, 4, -1, 16'h0);
        slot("f7s3", 3, 4'h0, 1'b0, 4, -1, 16'h0);

        // Frame 8: all zero, only digit 0 lit.
        slot("f8s0", 0, 4'h0, 1'b1, 4, 0, 16'h0000);
        slot("f8s1", 1, 4'h0, 1'b0, 4, -1, 16'h0);
        slot("f8s2", 2, 4'h0, 1'b0, 4, -1, 16'h0);
        slot("f8s3", 3, 4'h0, 1'b0, 4, -1, 16'h0);

        // Frame 9: back to 4321, drop enable mid-slot at index 2.
        bus.lz_blank = 1'b0;
        slot("f9s0", 0, 4'h1, 1'b1, 4, 0, 16'h4321);
        slot("f9s1", 1, 4'h2, 1'b1, 4, -1, 16'h0);
        slot("f9s2", 2, 4'h3, 1'b1, 2, -1, 16'h0);
        bus.enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("dis.anodo",   32'(bus.anodo),      32'h0);
            chk("dis.apagado", 32'(bus.apagado),    32'h1);
            chk("dis.fim",     32'(bus.fim_quadro), 32'h0);
        end
        bus.enable = 1'b1;

        // Restart from index 0 with guard first; snapshot preserved.
        slot("r1s0", 0, 4'h1, 1'b1, 4, -1, 16'h0);
        slot("r1s1", 1, 4'h2, 1'b1, 4, -1, 16'h0);
        slot("r1s2", 2, 4'h3, 1'b1, 4, -1, 16'h0);
        slot("r1s3", 3, 4'h4, 1'b1, 4, -1, 16'h0);

        // Reset pulse mid-SHOW at index 2, timer 1.
        slot("r2s0", 0, 4'h1, 1'b1, 4, -1, 16'h0);
        slot("r2s1", 1, 4'h2, 1'b1, 4, -1, 16'h0);
        slot("r2s2", 2, 4'h3, 1'b1, 2, -1, 16'h0);
        #2;
        reset = 1'b1;
        #1;
        chk_out("rst_mid", 4'h0, 4'b0000, 1'b1, 1'b0);
        reset = 1'b0;
        step();
        chk_out("post_rst.guard", 4'h0, 4'b0000, 1'b1, 1'b0);
        step();
        chk_out("post_rst.show", 4'h0, 4'b0001, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
